// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and helpers for the staged reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer state; encoding is exported directly on state_o.
    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_HOLD   = 2'd1,
        S_STAGE  = 2'd2,
        S_RUN    = 2'd3
    } seq_state_t;

    // Width of the shared hold/stage counter: wide enough for the larger count.
    function automatic int seq_cnt_width(input int hold_cycles, input int stage_cycles);
        int largest;
        largest = (hold_cycles > stage_cycles) ? hold_cycles : stage_cycles;
        if (largest < 1) begin
            largest = 1;
        end
        return $clog2(largest + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, polarity normalisation and stability
//               counter for a raw pushbutton. Output is the debounced
//               "pressed" level. Reusable for any board pushbutton.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic SYS_CLK,
    input  logic reset,
    input  logic btn_i,
    output logic btn_db_o
);

    // Raw pin level when the button is not pressed.
    localparam logic c_IDLE_LVL = BTN_ACTIVE_LOW;
    localparam int   c_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db;
    logic [c_DB_W-1:0] r_cnt;
    logic              w_pressed;

    // Normalise the synchronised pin to a "pressed" level.
    assign w_pressed = r_sync2 ^ c_IDLE_LVL;
    assign btn_db_o  = r_db;

    // Bring the asynchronous pin into the SYS_CLK domain.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            r_sync1 <= c_IDLE_LVL;
            r_sync2 <= c_IDLE_LVL;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // Change the debounced level only after the input differs for the full window.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_pressed == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
            r_cnt <= '0;
            r_db  <= ~r_db;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Board reset generator. Debounced pushbutton or a software
//               pulse asserts all N_CH reset outputs; after a hold time the
//               channels release one at a time, bit 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 50_000,
    parameter int STAGE_CYCLES    = 1024,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic            SYS_CLK,
    input  logic            reset,
    input  logic            btn_i,
    input  logic            sw_rst_i,
    output logic [N_CH-1:0] rst_o,
    output logic            done_o,
    output logic [1:0]      state_o,
    output logic            btn_db_o
);

    localparam int c_CNT_W = seq_cnt_width(HOLD_CYCLES, STAGE_CYCLES);
    localparam int c_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(STAGE_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]    c_BIT0       = N_CH'(1);

    seq_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [N_CH-1:0]    r_rst;
    logic               r_done;

    logic               w_btn_db;
    logic               w_req;
    logic [c_IDX_W-1:0] w_next_idx;
    logic [N_CH-1:0]    w_rel_mask;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_btn_debounce (
        .SYS_CLK  (SYS_CLK),
        .reset    (reset),
        .btn_i    (btn_i),
        .btn_db_o (w_btn_db)
    );

    // Software reset bypasses the debounce window.
    assign w_req      = w_btn_db | sw_rst_i;
    assign w_next_idx = r_idx + 1'b1;
    assign w_rel_mask = c_BIT0 << w_next_idx;

    assign rst_o    = r_rst;
    assign done_o   = r_done;
    assign state_o  = r_state;
    assign btn_db_o = w_btn_db;

    // Sequencer: assert all, hold, then release channels in order; a request always restarts.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else if (w_req) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_ASSERT: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                end
                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_rst[0] <= 1'b0;
                        if (N_CH == 1) begin
                            r_state <= S_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_STAGE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STAGE: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        r_cnt <= '0;
                        r_idx <= w_next_idx;
                        r_rst <= r_rst & ~w_rel_mask;
                        if (w_next_idx == c_IDX_LAST) begin
                            r_state <= S_RUN;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_rst  <= '0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_ASSERT;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rst   <= '1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
